uart_receiver: RTL

//   Serial-to-parallel UART receiver, 8N1, LSB first, 16x oversampled. Pairs with the

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter: the frame-format
//   defaults and the 2-bit FSM state encodings. Both ends of the link use the
//   same encodings.
//   No ports (package).
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_SYNC_STAGES = 2;

  typedef logic [1:0] uart_state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous serial line into the i_clk_in domain through a
//   chain of SYNC_STAGES flops. The chain resets to 1 (line idle) so that a
//   reset never looks like a start bit.
// Ports
//   i_clk_in  in   system clock
//   i_rst     in   synchronous, active-high reset
//   i_rx_in   in   asynchronous serial line
//   o_rxs     out  synchronized line (SYNC_STAGES cycles of latency)
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic i_clk_in,
  input  logic i_rst,
  input  logic i_rx_in,
  output logic o_rxs
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_in};
    end
  end

  assign o_rxs = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver, LSB first, oversampled by OVERSAMPLE ticks of the
//   i_clk_baud enable per bit. Each good byte is delivered with a one-cycle
//   o_rx_valid pulse; a frame whose stop bit reads 0 gives a one-cycle
//   o_frame_error pulse and leaves o_rx_data untouched.
// Ports
//   i_clk_in       in   system clock
//   i_rst          in   synchronous, active-high reset
//   i_clk_baud     in   one-cycle tick enable at OVERSAMPLE x baud rate
//   i_rx_in        in   asynchronous serial line, idle high
//   o_rx_data      out  last good byte, held until the next good frame
//   o_rx_valid     out  one-cycle pulse: o_rx_data updated
//   o_frame_error  out  one-cycle pulse: stop bit sampled low
//   o_busy         out  high while a frame is being received
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic                 i_clk_in,
  input  logic                 i_rst,
  input  logic                 i_clk_baud,
  input  logic                 i_rx_in,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Start bit is re-checked half a bit after the falling edge; every later
  // sample is one full bit further on, so all samples land mid-bit.
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 w_rxs;

  uart_state_t          r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_error;
  logic                 r_armed;

  uart_state_t          w_state_next;
  logic [TICK_W-1:0]    w_tick_next;
  logic [BIT_W-1:0]     w_bit_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] w_rx_data_next;
  logic                 w_rx_valid_next;
  logic                 w_frame_error_next;
  logic                 w_armed_next;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk_in (i_clk_in),
    .i_rst    (i_rst),
    .i_rx_in  (i_rx_in),
    .o_rxs    (w_rxs)
  );

  always_comb begin
    w_state_next       = r_state;
    w_tick_next        = r_tick;
    w_bit_next         = r_bit;
    w_shift_next       = r_shift;
    w_rx_data_next     = r_rx_data;
    w_armed_next       = r_armed;
    // Output strobes fall back to 0 every cycle, tick or not.
    w_rx_valid_next    = 1'b0;
    w_frame_error_next = 1'b0;

    if (i_clk_baud) begin
      case (r_state)
        IDLE: begin
          // A start edge is only honoured once the line has been seen high,
          // so a held-low line (break) cannot retrigger frames.
          if (w_rxs) begin
            w_armed_next = 1'b1;
          end else if (r_armed) begin
            w_state_next = START;
            w_tick_next  = '0;
          end
        end

        START: begin
          if (r_tick == MID_TICK) begin
            w_tick_next = '0;
            if (!w_rxs) begin
              w_state_next = DATA;
              w_bit_next   = '0;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              w_state_next = IDLE;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end

        DATA: begin
          if (r_tick == LAST_TICK) begin
            w_tick_next  = '0;
            w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit == LAST_BIT) begin
              w_state_next = STOP;
            end else begin
              w_bit_next = r_bit + 1'b1;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end

        STOP: begin
          if (r_tick == LAST_TICK) begin
            // Return to IDLE at mid stop bit so a start bit that follows
            // immediately is still caught at its falling edge.
            w_tick_next  = '0;
            w_bit_next   = '0;
            w_state_next = IDLE;
            if (w_rxs) begin
              w_rx_data_next  = r_shift;
              w_rx_valid_next = 1'b1;
            end else begin
              w_frame_error_next = 1'b1;
              w_armed_next       = 1'b0;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end

        default: begin
          w_state_next = IDLE;
          w_tick_next  = '0;
          w_bit_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tick        <= w_tick_next;
      r_bit         <= w_bit_next;
      r_shift       <= w_shift_next;
      r_rx_data     <= w_rx_data_next;
      r_rx_valid    <= w_rx_valid_next;
      r_frame_error <= w_frame_error_next;
      r_armed       <= w_armed_next;
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_frame_error = r_frame_error;
  assign o_busy        = (r_state != IDLE);

endmodule
